move_controller: RTL and testbench
==================================

// Module: move_controller
// PURPOSE
//  Game-logic stage directly downstream of the coordinate input stage. Consumes
//  each validated (x,y) pulse and checks bounds and occupancy. Places the current
//  player's mark (triangle/circle) on the board register file, then scans for a
//  WIN_LEN run through the new cell. Alternates turns and declares win/draw.
//  Exposes a read port for the display stage.
// PARAMETERS
//  GRID_SIZE  10  board is GRID_SIZE x GRID_SIZE; legal coords 0..GRID_SIZE-1
//  WIN_LEN    4   consecutive same marks (H, V, diag, anti-diag) needed to win
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high; clears board and all state
//  x_in           in   4   column from input stage, sampled when coord_valid=1
//  y_in           in   4   row from input stage, sampled when coord_valid=1
//  coord_valid    in   1   1-cycle pulse: new coordinate available
//  new_game       in   1   sync pulse: clear board, triangle to move, go IDLE
//  rd_x, rd_y     in   4   display read address (combinational read)
//  rd_cell        out  2   cell at (rd_x,rd_y); 00 if address out of range
//  cur_player     out  1   0=triangle, 1=circle (player to move)
//  busy           out  1   high in every state except IDLE and OVER
//  move_ok        out  1   1-cycle pulse: mark placed
//  move_bad       out  1   1-cycle pulse: rejected (out of range / occupied / OVER)
//  game_over      out  1   high in OVER
//  winner         out  2   00 none, 01 triangle, 10 circle, 11 draw
//  tri_count      out  7   marks placed by triangle
//  cir_count      out  7   marks placed by circle
// BEHAVIOUR
//  Reset: board all 00; state IDLE; cur_player=0; every output 0; counts 0.
//  Cell encoding: 00 empty, 01 triangle, 10 circle (11 unused).
//  FSM: IDLE, CHECK, PLACE, SCAN, NEXT, OVER.
//  - IDLE: coord_valid=1 -> latch x_in,y_in; go CHECK.
//  - CHECK (1 cycle): x>=GRID_SIZE, y>=GRID_SIZE or cell!=00 -> pulse move_bad,
//    go IDLE, player unchanged. Otherwise go PLACE.
//  - PLACE (1 cycle): write mark; pulse move_ok; increment that player's count.
//    Then go SCAN.
//  - SCAN: per direction d in {H,V,D,A}: run=1; step +d while in-bounds and same
//    mark and run<WIN_LEN; then step -d likewise. One cell per cycle.
//    Win when run==WIN_LEN: set winner=player+1, go OVER immediately.
//    Worst case 4*2*(WIN_LEN-1) cycles.
//  - NEXT (1 cycle): if tri_count+cir_count==GRID_SIZE^2 -> winner=11, go OVER.
//    Otherwise toggle cur_player, go IDLE.
//  - OVER: holds board, winner, game_over. Each coord_valid pulses move_bad.
//  coord_valid while busy: ignored, no pulse, not queued.
//  new_game: clears from any state at next edge. Beats coord_valid in same cycle.
//  Reset mid-SCAN: board cleared, no pulses emitted.
//  Neighbour bounds: compare signed 5-bit coords against 0..GRID_SIZE-1; no wrap.
//  move_ok and move_bad are never high together.
// STRUCTURE
//  Shared package game_pkg: cell codes (CELL_EMPTY/TRI/CIR), winner codes,
//  direction delta table (dx,dy per H/V/D/A), FSM state encoding.
//  Board = flat reg array GRID_SIZE*GRID_SIZE x 2 bits, index y*GRID_SIZE+x.
//  Sub-module run_scanner: walk-pointer, run counter and direction/sign
//  sequencing. Inputs start, origin, mark, cell data; outputs rd address,
//  done, won.
// TESTING
//  1 Reset, then pulse (3,4) -> move_ok 3 cycles later; rd(3,4)=01; cur_player=1;
//    tri_count=1.
//  2 Pulse (3,4) again while circle to move -> move_bad; board and player
//    unchanged.
//  3 Pulse (10,2) and (2,15) -> move_bad each; no count change.
//  4 Triangle at (0,0),(1,0),(2,0),(3,0), circle in row 5 between
//    -> after (3,0): winner=01, game_over=1. Next coord_valid -> move_bad.
//  5 Anti-diagonal circle (9,0),(8,1),(7,2),(6,3), placed in shuffled order
//    -> winner=10. Pulse new_game -> board empty, winner=00.
//  6 GRID_SIZE=3, WIN_LEN=3, full board with no line -> winner=11 after 9th
//    move. coord_valid during SCAN ignored (no pulse).

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the board game logic: cell and winner codes, FSM states,
// scan directions and their step deltas.
package game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_TRI   = 2'b01;
  localparam logic [1:0] CELL_CIR   = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TRI  = 2'b01;
  localparam logic [1:0] WIN_CIR  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PLACE,
    ST_SCAN,
    ST_NEXT,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_t;

  // Anti-diagonal steps right and up, so it covers (x+1,y-1)/(x-1,y+1).
  function automatic logic signed [4:0] dir_dx(input dir_t d);
    return (d == DIR_V) ? 5'sd0 : 5'sd1;
  endfunction

  function automatic logic signed [4:0] dir_dy(input dir_t d);
    logic signed [4:0] r;
    case (d)
      DIR_H:   r = 5'sd0;
      DIR_A:   r = -5'sd1;
      default: r = 5'sd1;
    endcase
    return r;
  endfunction

  function automatic logic coord_in_range(input logic signed [4:0] c, input int n);
    return (int'(c) >= 0) && (int'(c) < n);
  endfunction

endpackage

// File: rtl/run_scanner.sv
// Walks outward from a freshly placed cell in each of the four directions,
// one neighbour per cycle, and reports whether a WIN_LEN run passes through it.
module run_scanner
  import game_pkg::*;
#(
  parameter int GRID_SIZE = 10,
  parameter int WIN_LEN   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        origin_x,
  input  logic [3:0]        origin_y,
  input  logic [1:0]        mark,
  input  logic [1:0]        cell_data,
  output logic signed [4:0] rd_x,
  output logic signed [4:0] rd_y,
  output logic              done,
  output logic              won
);

  logic              active_reg;
  dir_t              dir_reg;
  logic              neg_reg;
  logic [3:0]        run_reg;
  logic [1:0]        mark_reg;
  logic signed [4:0] org_x_reg, org_y_reg;
  logic signed [4:0] pos_x_reg, pos_y_reg;
  logic signed [4:0] step_x, step_y;
  logic              extend;

  // rd_x/rd_y is the candidate neighbour; the top returns its contents on cell_data.
  always_comb begin
    step_x = neg_reg ? -dir_dx(dir_reg) : dir_dx(dir_reg);
    step_y = neg_reg ? -dir_dy(dir_reg) : dir_dy(dir_reg);
    rd_x   = pos_x_reg + step_x;
    rd_y   = pos_y_reg + step_y;
    extend = active_reg && coord_in_range(rd_x, GRID_SIZE) &&
             coord_in_range(rd_y, GRID_SIZE) && (cell_data == mark_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_reg <= 1'b0;
      dir_reg    <= DIR_H;
      neg_reg    <= 1'b0;
      run_reg    <= 4'd0;
      mark_reg   <= CELL_EMPTY;
      org_x_reg  <= 5'sd0;
      org_y_reg  <= 5'sd0;
      pos_x_reg  <= 5'sd0;
      pos_y_reg  <= 5'sd0;
      done       <= 1'b0;
      won        <= 1'b0;
    end else begin
      done <= 1'b0;
      won  <= 1'b0;
      if (clear) begin
        active_reg <= 1'b0;
      end else if (start) begin
        active_reg <= 1'b1;
        dir_reg    <= DIR_H;
        neg_reg    <= 1'b0;
        run_reg    <= 4'd1;
        mark_reg   <= mark;
        org_x_reg  <= signed'({1'b0, origin_x});
        org_y_reg  <= signed'({1'b0, origin_y});
        pos_x_reg  <= signed'({1'b0, origin_x});
        pos_y_reg  <= signed'({1'b0, origin_y});
      end else if (active_reg) begin
        if (extend) begin
          if (run_reg + 4'd1 == 4'(WIN_LEN)) begin
            done       <= 1'b1;
            won        <= 1'b1;
            active_reg <= 1'b0;
          end else begin
            run_reg   <= run_reg + 4'd1;
            pos_x_reg <= rd_x;
            pos_y_reg <= rd_y;
          end
        end else if (!neg_reg) begin
          // Positive half ended; walk the negative half keeping the run so far.
          neg_reg   <= 1'b1;
          pos_x_reg <= org_x_reg;
          pos_y_reg <= org_y_reg;
        end else if (dir_reg == DIR_A) begin
          done       <= 1'b1;
          active_reg <= 1'b0;
        end else begin
          dir_reg   <= dir_t'(dir_reg + 2'd1);
          neg_reg   <= 1'b0;
          run_reg   <= 4'd1;
          pos_x_reg <= org_x_reg;
          pos_y_reg <= org_y_reg;
        end
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// Validates incoming moves, places marks on the board, runs the win scan and
// sequences turns; exposes a combinational board read port for the display.
module move_controller
  import game_pkg::*;
#(
  parameter int GRID_SIZE = 10,
  parameter int WIN_LEN   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       coord_valid,
  input  logic       new_game,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_cell,
  output logic       cur_player,
  output logic       busy,
  output logic       move_ok,
  output logic       move_bad,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] tri_count,
  output logic [6:0] cir_count
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int AW    = $clog2(CELLS);

  function automatic logic [AW-1:0] cell_idx(input logic [3:0] cx, input logic [3:0] cy);
    return AW'(int'(cy) * GRID_SIZE + int'(cx));
  endfunction

  logic [1:0]        board_reg [CELLS];
  state_t            state_reg;
  logic [3:0]        x_reg, y_reg;
  logic              scan_start_reg;
  logic signed [4:0] scan_rd_x, scan_rd_y;
  logic [1:0]        scan_cell;
  logic              scan_done, scan_won;
  logic              chk_in_range;
  logic [1:0]        chk_cell;
  logic [1:0]        place_mark;

  always_comb begin
    rd_cell = CELL_EMPTY;
    if (int'(rd_x) < GRID_SIZE && int'(rd_y) < GRID_SIZE)
      rd_cell = board_reg[cell_idx(rd_x, rd_y)];

    chk_in_range = (int'(x_reg) < GRID_SIZE) && (int'(y_reg) < GRID_SIZE);
    chk_cell     = CELL_EMPTY;
    if (chk_in_range)
      chk_cell = board_reg[cell_idx(x_reg, y_reg)];

    scan_cell = CELL_EMPTY;
    if (coord_in_range(scan_rd_x, GRID_SIZE) && coord_in_range(scan_rd_y, GRID_SIZE))
      scan_cell = board_reg[cell_idx(scan_rd_x[3:0], scan_rd_y[3:0])];

    place_mark = cur_player ? CELL_CIR : CELL_TRI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) board_reg[i] <= CELL_EMPTY;
    end else if (new_game) begin
      for (int i = 0; i < CELLS; i++) board_reg[i] <= CELL_EMPTY;
    end else if (state_reg == ST_PLACE) begin
      board_reg[cell_idx(x_reg, y_reg)] <= place_mark;
    end
  end

  run_scanner #(
    .GRID_SIZE (GRID_SIZE),
    .WIN_LEN   (WIN_LEN)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .clear     (new_game),
    .start     (scan_start_reg),
    .origin_x  (x_reg),
    .origin_y  (y_reg),
    .mark      (place_mark),
    .cell_data (scan_cell),
    .rd_x      (scan_rd_x),
    .rd_y      (scan_rd_y),
    .done      (scan_done),
    .won       (scan_won)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      x_reg          <= 4'd0;
      y_reg          <= 4'd0;
      scan_start_reg <= 1'b0;
      cur_player     <= 1'b0;
      busy           <= 1'b0;
      move_ok        <= 1'b0;
      move_bad       <= 1'b0;
      game_over      <= 1'b0;
      winner         <= WIN_NONE;
      tri_count      <= 7'd0;
      cir_count      <= 7'd0;
    end else begin
      move_ok        <= 1'b0;
      move_bad       <= 1'b0;
      scan_start_reg <= 1'b0;
      if (new_game) begin
        state_reg  <= ST_IDLE;
        cur_player <= 1'b0;
        busy       <= 1'b0;
        game_over  <= 1'b0;
        winner     <= WIN_NONE;
        tri_count  <= 7'd0;
        cir_count  <= 7'd0;
      end else begin
        case (state_reg)
          ST_IDLE: if (coord_valid) begin
            x_reg     <= x_in;
            y_reg     <= y_in;
            busy      <= 1'b1;
            state_reg <= ST_CHECK;
          end
          ST_CHECK: if (!chk_in_range || chk_cell != CELL_EMPTY) begin
            move_bad  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_PLACE;
          end
          ST_PLACE: begin
            move_ok        <= 1'b1;
            scan_start_reg <= 1'b1;
            if (cur_player) cir_count <= cir_count + 7'd1;
            else            tri_count <= tri_count + 7'd1;
            state_reg <= ST_SCAN;
          end
          ST_SCAN: if (scan_done) begin
            if (scan_won) begin
              winner    <= cur_player ? WIN_CIR : WIN_TRI;
              game_over <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_OVER;
            end else begin
              state_reg <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            busy <= 1'b0;
            // Counts already include the mark placed this turn.
            if ({1'b0, tri_count} + {1'b0, cir_count} == 8'(CELLS)) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state_reg <= ST_OVER;
            end else begin
              cur_player <= ~cur_player;
              state_reg  <= ST_IDLE;
            end
          end
          ST_OVER: if (coord_valid) move_bad <= 1'b1;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench: a 10x10/WIN_LEN=4 instance for most scenarios and a 3x3/WIN_LEN=3
// instance for the full-board draw; sel chooses which one the tasks drive and observe.
module tb_move_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic [3:0] x_in = 4'd0, y_in = 4'd0, rd_x = 4'd0, rd_y = 4'd0;
  logic       cv = 1'b0, ng = 1'b0;

  logic [1:0] cell_a, win_a, cell_b, win_b;
  logic       pl_a, busy_a, ok_a, bad_a, over_a;
  logic       pl_b, busy_b, ok_b, bad_b, over_b;
  logic [6:0] tri_a, cir_a, tri_b, cir_b;

  logic [1:0] o_cell, o_win;
  logic       o_pl, o_busy, o_ok, o_bad, o_over;
  logic [6:0] o_tri, o_cir;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  move_controller #(.GRID_SIZE(10), .WIN_LEN(4)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .coord_valid(cv & ~sel), .new_game(ng & ~sel), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(cell_a), .cur_player(pl_a), .busy(busy_a), .move_ok(ok_a),
    .move_bad(bad_a), .game_over(over_a), .winner(win_a),
    .tri_count(tri_a), .cir_count(cir_a)
  );

  move_controller #(.GRID_SIZE(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .coord_valid(cv & sel), .new_game(ng & sel), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(cell_b), .cur_player(pl_b), .busy(busy_b), .move_ok(ok_b),
    .move_bad(bad_b), .game_over(over_b), .winner(win_b),
    .tri_count(tri_b), .cir_count(cir_b)
  );

  assign o_cell = sel ? cell_b : cell_a;
  assign o_win  = sel ? win_b  : win_a;
  assign o_pl   = sel ? pl_b   : pl_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_ok   = sel ? ok_b   : ok_a;
  assign o_bad  = sel ? bad_b  : bad_a;
  assign o_over = sel ? over_b : over_a;
  assign o_tri  = sel ? tri_b  : tri_a;
  assign o_cir  = sel ? cir_b  : cir_a;

  // Move sequences: T = triangle, C = circle, alternating from triangle.
  int t4x[7] = '{0, 0, 1, 1, 2, 2, 3};
  int t4y[7] = '{0, 5, 0, 5, 0, 5, 0};
  int t5x[8] = '{0, 7, 1, 9, 3, 6, 5, 8};
  int t5y[8] = '{9, 2, 9, 0, 9, 3, 9, 1};
  int t6x[9] = '{0, 1, 2, 1, 0, 2, 2, 0, 1};
  int t6y[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!o_busy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 1, 0);
  endtask

  // result: 0 no pulse, 1 move_ok, 2 move_bad; lat counts edges after coord_valid was sampled+1.
  task automatic move(input int x, input int y, output int result, output int lat);
    @(posedge clk); #1;
    x_in = 4'(x); y_in = 4'(y); cv = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0;
    result = 0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (o_ok && o_bad) check("ok_bad_exclusive", 1, 0);
      if (o_ok)  begin result = 1; lat = i; break; end
      if (o_bad) begin result = 2; lat = i; break; end
      @(posedge clk); #1;
    end
    wait_idle();
    $display("move (%0d,%0d) result=%0d latency=%0d player=%0d winner=%0d",
             x, y, result, lat, o_pl, o_win);
  endtask

  task automatic read_cell(input int x, input int y, output int v);
    rd_x = 4'(x); rd_y = 4'(y);
    #1;
    v = int'(o_cell);
  endtask

  task automatic pulse_new_game();
    @(posedge clk); #1; ng = 1'b1;
    @(posedge clk); #1; ng = 1'b0;
    $display("new_game sel=%0d", sel);
  endtask

  initial begin
    int r, l, v, extra;

    repeat (3) @(posedge clk);
    #1;
    check("rst_player", o_pl, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ok", o_ok, 0);
    check("rst_bad", o_bad, 0);
    check("rst_over", o_over, 0);
    check("rst_winner", o_win, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_tri", o_tri, 0);
    check("rst_cir", o_cir, 0);
    read_cell(3, 4, v);
    check("rst_cell", v, 0);

    // Test 1
    move(3, 4, r, l);
    check("t1_result", r, 1);
    check("t1_latency", l, 3);
    read_cell(3, 4, v);
    check("t1_cell", v, 1);
    check("t1_player", o_pl, 1);
    check("t1_tri", o_tri, 1);
    check("t1_cir", o_cir, 0);

    // Test 2
    move(3, 4, r, l);
    check("t2_result", r, 2);
    check("t2_latency", l, 2);
    read_cell(3, 4, v);
    check("t2_cell", v, 1);
    check("t2_player", o_pl, 1);

    // Test 3
    move(10, 2, r, l);
    check("t3_xbad", r, 2);
    move(2, 15, r, l);
    check("t3_ybad", r, 2);
    check("t3_tri", o_tri, 1);
    check("t3_cir", o_cir, 0);
    read_cell(12, 3, v);
    check("t3_rd_oob", v, 0);

    pulse_new_game();
    check("ng1_player", o_pl, 0);
    check("ng1_tri", o_tri, 0);
    read_cell(3, 4, v);
    check("ng1_cell", v, 0);

    // Test 4: horizontal triangle win
    for (int i = 0; i < 7; i++) begin
      move(t4x[i], t4y[i], r, l);
      check($sformatf("t4_move%0d", i), r, 1);
    end
    check("t4_winner", o_win, 1);
    check("t4_over", o_over, 1);
    check("t4_busy", o_busy, 0);
    check("t4_tri", o_tri, 4);
    check("t4_cir", o_cir, 3);
    move(5, 5, r, l);
    check("t4_after_over", r, 2);
    check("t4_after_over_lat", l, 1);
    read_cell(5, 5, v);
    check("t4_after_cell", v, 0);
    check("t4_winner_hold", o_win, 1);

    pulse_new_game();

    // Test 5: anti-diagonal circle win, placed out of order
    for (int i = 0; i < 8; i++) begin
      move(t5x[i], t5y[i], r, l);
      check($sformatf("t5_move%0d", i), r, 1);
      if (i < 7) check($sformatf("t5_nowin%0d", i), o_win, 0);
    end
    check("t5_winner", o_win, 2);
    check("t5_over", o_over, 1);
    check("t5_cir", o_cir, 4);
    read_cell(7, 2, v);
    check("t5_cell72", v, 2);
    pulse_new_game();
    check("t5_ng_winner", o_win, 0);
    check("t5_ng_over", o_over, 0);
    check("t5_ng_cir", o_cir, 0);
    read_cell(8, 1, v);
    check("t5_ng_cell81", v, 0);
    read_cell(0, 9, v);
    check("t5_ng_cell09", v, 0);

    // Test 6: 3x3 draw, plus a coord_valid dropped during SCAN
    sel = 1'b1;
    #1;
    @(posedge clk); #1;
    x_in = 4'd0; y_in = 4'd0; cv = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_first_ok", o_ok, 1);
    x_in = 4'd2; y_in = 4'd2; cv = 1'b1;
    @(posedge clk); #1;
    cv = 1'b0;
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_ok || o_bad) extra++;
      if (!o_busy) break;
      @(posedge clk); #1;
    end
    $display("move (0,0) with (2,2) injected during scan, extra pulses=%0d", extra);
    check("t6_scan_ignore", extra, 0);
    check("t6_busy_done", o_busy, 0);
    read_cell(2, 2, v);
    check("t6_ignored_cell", v, 0);
    check("t6_tri1", o_tri, 1);
    check("t6_player", o_pl, 1);

    for (int i = 1; i < 9; i++) begin
      move(t6x[i], t6y[i], r, l);
      check($sformatf("t6_move%0d", i), r, 1);
      if (i < 8) check($sformatf("t6_nodraw%0d", i), o_win, 0);
    end
    check("t6_winner", o_win, 3);
    check("t6_over", o_over, 1);
    check("t6_tri", o_tri, 5);
    check("t6_cir", o_cir, 4);
    move(1, 1, r, l);
    check("t6_after_over", r, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
